// File: rtl/manual_drive.sv
// Manual driving controller: pedal/gear FSM with engine-kill latch, motion
// commands, turn-lamp blinker and a mileage odometer, all on the 1 kHz tick.
module manual_drive #(
  parameter logic [1:0] MANUAL_MODE = 2'b00,
  parameter int         MILE_TICKS  = 1000,
  parameter int         BLINK_HALF  = 500
) (
  input  logic        clk_ms,
  input  logic        rst,
  input  logic [1:0]  global_state,
  input  logic        power,
  input  logic        throttle,
  input  logic        clutch,
  input  logic        brake,
  input  logic        reverse,
  input  logic        turn_left,
  input  logic        turn_right,
  output logic        manual_power,
  output logic [1:0]  drive_state,
  output logic        move_fwd,
  output logic        move_bwd,
  output logic        left_led,
  output logic        right_led,
  output logic [23:0] mileage
);
  localparam int MPW = (MILE_TICKS > 1) ? $clog2(MILE_TICKS) : 1;
  localparam int BPW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [1:0] NOT_STARTING = 2'b00;
  localparam logic [1:0] STARTING     = 2'b01;
  localparam logic [1:0] MOVING       = 2'b10;

  logic [1:0]     state_q, state_d;
  logic           kill_q, kill_d;
  logic           rev_q;
  logic           mpow_q, mpow_d;
  logic           fwd_q, fwd_d, bwd_q, bwd_d;
  logic           lled_q, lled_d, rled_q, rled_d;
  logic [23:0]    mileage_q, mileage_d;
  logic [MPW-1:0] mpre_q, mpre_d;
  logic [BPW-1:0] bcnt_q, bcnt_d;
  logic           phase_q, phase_d;

  logic enabled, viol;

  assign enabled = (global_state == MANUAL_MODE) && power;

  // A violation is only meaningful while the block is live and not already killed.
  assign viol = enabled && !kill_q &&
                (((state_q == NOT_STARTING) && throttle && !clutch && !brake) ||
                 ((state_q == MOVING) && (reverse != rev_q) && !clutch));

  // State register
  always_ff @(posedge clk_ms) begin
    if (rst) begin
      state_q   <= NOT_STARTING;
      kill_q    <= 1'b0;
      rev_q     <= reverse;
      mpow_q    <= 1'b0;
      fwd_q     <= 1'b0;
      bwd_q     <= 1'b0;
      lled_q    <= 1'b0;
      rled_q    <= 1'b0;
      mileage_q <= '0;
      mpre_q    <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      rev_q     <= reverse;
      mpow_q    <= mpow_d;
      fwd_q     <= fwd_d;
      bwd_q     <= bwd_d;
      lled_q    <= lled_d;
      rled_q    <= rled_d;
      mileage_q <= mileage_d;
      mpre_q    <= mpre_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
    end
  end

  // Next-state logic: violation > brake > pedal transitions
  always_comb begin
    state_d = NOT_STARTING;
    if (enabled && !kill_q && !viol && !brake) begin
      case (state_q)
        NOT_STARTING: state_d = (throttle && clutch) ? STARTING : NOT_STARTING;
        STARTING:     state_d = (throttle && !clutch) ? MOVING : STARTING;
        MOVING:       state_d = (!throttle || clutch) ? STARTING : MOVING;
        default:      state_d = NOT_STARTING;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    kill_d    = power && (kill_q || viol);
    mpow_d    = power && !kill_d;
    fwd_d     = (state_d == MOVING) && !reverse;
    bwd_d     = (state_d == MOVING) && reverse;

    mileage_d = mileage_q;
    mpre_d    = mpre_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    if (!enabled) begin
      mpre_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else begin
      // Prescaler only advances in MOVING and otherwise holds its count.
      if (state_q == MOVING) begin
        if (mpre_q == MPW'(MILE_TICKS - 1)) begin
          mpre_d    = '0;
          mileage_d = mileage_q + 24'd1;
        end else begin
          mpre_d = mpre_q + MPW'(1);
        end
      end
      if (bcnt_q == BPW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        bcnt_d = bcnt_q + BPW'(1);
      end
    end
    lled_d = enabled && turn_left && phase_d;
    rled_d = enabled && turn_right && phase_d;
  end

  assign manual_power = mpow_q;
  assign drive_state  = state_q;
  assign move_fwd     = fwd_q;
  assign move_bwd     = bwd_q;
  assign left_led     = lled_q;
  assign right_led    = rled_q;
  assign mileage      = mileage_q;
endmodule
